// File: rtl/nspp_types_pkg.sv
// Shared types for the N-stage pipeline register chain and the core stages it connects.
package nspp_types_pkg;

    localparam int unsigned NSPP_MAX_STAGES = 8;

    typedef logic [NSPP_MAX_STAGES-1:0] stage_mask_t;

    // Stage-control payload carried between core stages; opaque to the chain itself.
    typedef struct packed {
        logic        op_valid;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic [31:0] pc;
    } pipe_ctrl_t;

    function automatic int unsigned stage_count(input stage_mask_t mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(NSPP_MAX_STAGES); i++) begin
            n = n + 32'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/nspp_pipe_stage.sv
// One pipeline slot: valid bit plus payload register with advance, flush and reset.
module nspp_pipe_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    // Flush wins over advance for the valid bit; data only moves on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (advance) begin
                valid <= src_valid;
            end
            if (advance) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/nspp_pipe_chain.sv
// N-stage ready/valid register chain with bubble collapse and per-stage flush.
module nspp_pipe_chain
    import nspp_types_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic [NUM_STAGES-1:0]          flush,
    output logic [NUM_STAGES-1:0]          stage_valid,
    output logic [$clog2(NUM_STAGES+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);

    if (NUM_STAGES < 1 || NUM_STAGES > NSPP_MAX_STAGES) begin : g_bad_stages
        $fatal(1, "nspp_pipe_chain: NUM_STAGES must be in 1..8");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "nspp_pipe_chain: DATA_WIDTH must be at least 1");
    end

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] rdy;
    logic [DATA_WIDTH-1:0] data_q [NUM_STAGES];

    // A stage can take new content if it is empty or its occupant moves on this cycle.
    always_comb begin
        rdy                 = '0;
        rdy[NUM_STAGES-1]   = ~valid[NUM_STAGES-1] | out_ready;
        for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
            rdy[i] = ~valid[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
        logic                  src_valid;
        logic [DATA_WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = valid[i-1];
            assign src_data  = data_q[i-1];
        end

        nspp_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk       (CLK),
            .rst       (RST),
            .advance   (rdy[i]),
            .flush     (flush[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (valid[i]),
            .data      (data_q[i])
        );
    end

    assign in_ready    = rdy[0];
    assign out_valid   = valid[NUM_STAGES-1];
    assign out_data    = data_q[NUM_STAGES-1];
    assign stage_valid = valid;

    always_comb begin
        occupancy = OCC_W'(stage_count(stage_mask_t'(valid)));
    end

endmodule
